// File: rtl/mold_msg_fifo_pkg.sv
// ---------------------------------------------------------------------------
// moldudp64_pkg
//   Shared definitions for the moldudp64 message FIFO slice.
//   - Default AXI-stream widths used by mold_msg_fifo.
//   - Write-side FSM state encoding.
//   - Storage entry layout {data, keep, last} at the default widths.
// ---------------------------------------------------------------------------
package moldudp64_pkg;

    localparam int DEF_AXI_DATA_W = 64;
    localparam int DEF_AXI_KEEP_W = DEF_AXI_DATA_W / 8;

    // Write-side message FSM:
    //   IDLE    - between messages, waiting for a start beat
    //   WRITE   - inside an accepted message, beats go to storage
    //   DISCARD - inside a dropped message, beats are swallowed until last
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

    // One storage entry. Field order matches the packing used by the FIFO
    // top, so a flat entry word can be assigned straight to this type.
    typedef struct packed {
        logic [DEF_AXI_DATA_W-1:0] data;
        logic [DEF_AXI_KEEP_W-1:0] keep;
        logic                      last;
    } msg_entry_t;

endpackage

// File: rtl/mold_msg_fifo_mem.sv
// ---------------------------------------------------------------------------
// mold_msg_fifo_mem
//   DEPTH x WIDTH register array, one synchronous write port and one
//   asynchronous (combinational) read port.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write entry
//   raddr  in   read address
//   rdata  out  entry at raddr, combinational
// ---------------------------------------------------------------------------
module mold_msg_fifo_mem
    import moldudp64_pkg::*;
#(
    parameter int WIDTH = 73,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; pointers decide what is valid, so stale
    // contents are never observed and the array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mold_msg_fifo.sv
// ---------------------------------------------------------------------------
// mold_msg_fifo
//   Packet-mode message FIFO behind moldudp64. Beats are absorbed every
//   cycle they are valid (the source has no ready). A message is exposed to
//   the AXI-stream side only after its last beat is stored (commit); a
//   message that does not fit is removed whole (rollback) and counted.
//
// Ports:
//   clk                in   clock
//   reset              in   asynchronous active-high reset
//   mold_msg_v_i       in   beat valid
//   mold_msg_start_i   in   first beat of a message
//   mold_msg_last_i    in   last beat of a message
//   mold_msg_mask_i    in   byte-valid mask, contiguous from lane 0
//   mold_msg_data_i    in   beat data
//   msg_axis_tvalid_o  out  committed beat available
//   msg_axis_tready_i  in   downstream ready
//   msg_axis_tdata_o   out  beat data
//   msg_axis_tkeep_o   out  beat byte mask
//   msg_axis_tlast_o   out  last beat of message
//   drop_v_o           out  one-cycle pulse per dropped message
//   drop_cnt_o         out  saturating dropped-message count
// ---------------------------------------------------------------------------
module mold_msg_fifo
    import moldudp64_pkg::*;
#(
    parameter int AXI_DATA_W = DEF_AXI_DATA_W,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mold_msg_v_i,
    input  logic                  mold_msg_start_i,
    input  logic                  mold_msg_last_i,
    input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
    output logic                  msg_axis_tvalid_o,
    input  logic                  msg_axis_tready_i,
    output logic [AXI_DATA_W-1:0] msg_axis_tdata_o,
    output logic [AXI_KEEP_W-1:0] msg_axis_tkeep_o,
    output logic                  msg_axis_tlast_o,
    output logic                  drop_v_o,
    output logic [CNT_W-1:0]      drop_cnt_o
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = AXI_DATA_W + AXI_KEEP_W + 1;

    // Pointers carry one extra bit so full and empty are distinguishable.
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0]      PTR_CAP = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wr_state_t   state;
    logic [AW:0] wr_ptr;
    logic [AW:0] cmt_ptr;
    logic [AW:0] rd_ptr;

    wr_state_t   state_nxt;
    logic [AW:0] wr_base;
    logic [AW:0] wr_nxt;
    logic [AW:0] cmt_nxt;
    logic        we;
    logic        drop;
    logic        new_msg;
    logic        rd_fire;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // -----------------------------------------------------------------------
    // Write-side decode. wr_base is where a beat would land this cycle: the
    // speculative pointer, or the commit pointer when a start beat arrives
    // inside an open message and that message is being abandoned. Fullness
    // is judged on registered pointers only, so a read in the same cycle
    // does not make room.
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        wr_base   = wr_ptr;
        wr_nxt    = wr_ptr;
        cmt_nxt   = cmt_ptr;
        we        = 1'b0;
        drop      = 1'b0;
        new_msg   = 1'b0;

        if (mold_msg_v_i) begin
            case (state)
                IDLE: begin
                    // Orphan continuation beats are ignored silently.
                    new_msg = mold_msg_start_i;
                end

                DISCARD: begin
                    if (mold_msg_start_i) begin
                        new_msg = 1'b1;
                    end else if (mold_msg_last_i) begin
                        state_nxt = IDLE;
                    end
                end

                WRITE: begin
                    if (mold_msg_start_i) begin
                        // Previous message never saw its last beat: drop it
                        // and treat this beat as a fresh message start.
                        drop      = 1'b1;
                        wr_base   = cmt_ptr;
                        wr_nxt    = cmt_ptr;
                        state_nxt = IDLE;
                        new_msg   = 1'b1;
                    end else if ((wr_ptr - rd_ptr) != PTR_CAP) begin
                        we     = 1'b1;
                        wr_nxt = wr_ptr + PTR_ONE;
                        if (mold_msg_last_i) begin
                            cmt_nxt   = wr_ptr + PTR_ONE;
                            state_nxt = IDLE;
                        end
                    end else begin
                        wr_nxt    = cmt_ptr;
                        drop      = 1'b1;
                        state_nxt = mold_msg_last_i ? IDLE : DISCARD;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (new_msg) begin
                if ((wr_base - rd_ptr) != PTR_CAP) begin
                    we     = 1'b1;
                    wr_nxt = wr_base + PTR_ONE;
                    if (mold_msg_last_i) begin
                        cmt_nxt   = wr_base + PTR_ONE;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WRITE;
                    end
                end else begin
                    // A drop already flagged for an abandoned message keeps
                    // this to a single pulse.
                    drop      = 1'b1;
                    state_nxt = mold_msg_last_i ? IDLE : DISCARD;
                end
            end
        end
    end

    assign rd_fire  = msg_axis_tvalid_o && msg_axis_tready_i;
    assign wr_entry = {mold_msg_data_i, mold_msg_mask_i, mold_msg_last_i};

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            drop_v_o   <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_nxt;
            cmt_ptr  <= cmt_nxt;
            drop_v_o <= drop;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop && (drop_cnt_o != {CNT_W{1'b1}})) begin
                drop_cnt_o <= drop_cnt_o + CNT_ONE;
            end
        end
    end

    mold_msg_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_base[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    // Only committed beats are visible; read data follows rd_ptr directly
    // and therefore holds while the consumer stalls.
    assign msg_axis_tvalid_o = (rd_ptr != cmt_ptr);
    assign {msg_axis_tdata_o, msg_axis_tkeep_o, msg_axis_tlast_o} = rd_entry;

endmodule

// File: doc/mold_msg_fifo.md
Name: mold_msg_fifo

Overview:
- Packet-mode message FIFO directly downstream of moldudp64. It buffers moldudp64 message beats and presents them on an AXI-stream master with backpressure.
- moldudp64 has no ready input, so this block absorbs its output unconditionally.
- A message becomes visible downstream only once its last beat is written (commit). A message that cannot fit is dropped whole (rollback), never truncated.

Parameters:
- AXI_DATA_W, 64, data width in bits.
- AXI_KEEP_W, AXI_DATA_W/8, byte-mask width.
- DEPTH, 16, storage depth in beats; must be a power of 2, at least 2.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- mold_msg_v_i  in  1  beat valid from moldudp64.
- mold_msg_start_i  in  1  first beat of a message.
- mold_msg_last_i  in  1  final beat of a message; moldudp64 drives it.
- mold_msg_mask_i  in  AXI_KEEP_W  byte valid, contiguous from lane 0.
- mold_msg_data_i  in  AXI_DATA_W  message bytes.
- msg_axis_tvalid_o  out  1  committed beat available.
- msg_axis_tready_i  in  1  downstream ready.
- msg_axis_tdata_o  out  AXI_DATA_W  beat data.
- msg_axis_tkeep_o  out  AXI_KEEP_W  beat mask.
- msg_axis_tlast_o  out  1  last beat of message.
- drop_v_o  out  1  one-cycle pulse, one per dropped message.
- drop_cnt_o  out  CNT_W  saturating count of dropped messages.

Behaviour:
- Storage entry is {data, keep, last}.
- Pointers wr_ptr (speculative), cmt_ptr (commit) and rd_ptr are each log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- full = (wr_ptr - rd_ptr) == DEPTH, evaluated on registered pointers. A same-cycle read does not relieve full.
- Write FSM has three states: IDLE, WRITE, DISCARD.
- IDLE, v&start&~full: write the beat, wr_ptr+1.
  - If last: cmt_ptr <= wr_ptr+1, stay in IDLE.
  - Otherwise: go to WRITE.
- IDLE, v&start&full: pulse drop_v.
  - If last: stay in IDLE.
  - Otherwise: go to DISCARD.
- IDLE, v&~start (orphan beat): ignored, no drop pulse.
- WRITE, v&~start&~full: write the beat.
  - If last: commit and go to IDLE.
- WRITE, v&~start&full: wr_ptr <= cmt_ptr (rollback) and pulse drop_v.
  - If last: go to IDLE.
  - Otherwise: go to DISCARD.
- WRITE, v&start (missing last, protocol error): roll back the open message and pulse drop_v. The new beat is then processed exactly as in IDLE, using post-rollback pointers. Only one drop pulse is issued that cycle, for the old message.
- DISCARD, v&~start: ignored. If last: go to IDLE.
- DISCARD, v&start: processed as in IDLE.
- Any message longer than DEPTH beats is always dropped.
- drop_cnt_o increments on every drop_v pulse and saturates at all-ones.
- Read side:
  - msg_axis_tvalid_o = (rd_ptr != cmt_ptr).
  - tdata/tkeep/tlast are read combinationally from mem[rd_ptr] and stay stable while valid&~ready.
  - rd_ptr+1 on valid&ready.
- Latency: a last beat written at edge N gives tvalid at cycle N+1, assuming the FIFO was empty.
- Simultaneous events: a commit and a read in the same cycle are both honoured. A rollback never moves wr_ptr below cmt_ptr.
- Reset (async, any time, including mid-message):
  - all pointers 0, FSM in IDLE;
  - tvalid=0, drop_v=0, drop_cnt=0;
  - uncommitted and unread data is lost.
- Outputs while tvalid=0 are don't-care. tlast/tkeep are never X when tvalid=1.

Decomposition:
- Package moldudp64_pkg holds:
  - the AXI_DATA_W/AXI_KEEP_W defaults;
  - the write-FSM enum {IDLE, WRITE, DISCARD};
  - the entry struct {data, keep, last}.
- One sub-module, mold_msg_fifo_mem: a DEPTH x entry register array with one write port and one asynchronous read port. The pointer and FSM logic stays in the top.

Test Plan:
1. Three messages of 16/8/11 bytes, tready=1 -> output is three messages:
   - 2 beats with keep FF,FF;
   - 1 beat with keep FF;
   - 2 beats with keep FF,07.
   Checks: tlast on beats 2, 3 and 5; drop_cnt=0; first tvalid one cycle after the first last beat.
2. DEPTH=4, tready=0, 5-beat message then a 2-beat message -> drop_v pulses once and drop_cnt=1. After tready=1, only the 2-beat message is output, with its data intact.
3. DEPTH=4, 3-beat message committed, tready=0, then a 2-beat message -> the second message fills the 4th slot, hits full, rolls back and drop_cnt=1. The 3-beat message still drains correctly.
4. 3-beat message with last missing, followed by start of a 1-beat last message -> one drop_v pulse. Output is only the 1-beat message; no bytes from the orphaned message appear.
5. tready toggling every cycle while committing consecutive messages -> beat order is preserved, no duplicated or lost beats, data stable while stalled.
6. Assert reset after beat 2 of a 3-beat message, with 1 committed unread message -> tvalid=0 and drop_cnt=0 immediately. A new 1-beat message then passes with 1-cycle latency.
